nios_pushbutton_debounce: RTL and testbench
===========================================

// Module: nios_pushbutton_debounce
// PURPOSE
//  Conditions one raw, asynchronous, bouncing board pushbutton for the Nios
//  pushbutton PIO, which samples btn_level on its in_port.
//  - Synchronises the raw input into the clk domain.
//  - Debounces it with a per-button stability counter.
//  - Emits one-cycle press/release strobes and an 8-bit wrap-around press counter.
// PARAMETERS
//  SYNC_STAGES      2       synchroniser flops; legal >= 2
//  DEBOUNCE_CYCLES  500000  consecutive cycles of stable new level needed (10 ms @ 50 MHz); legal >= 1
//  ACTIVE_LOW       1       1: raw pin reads 0 when pressed; 0: reads 1 when pressed
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  derived, not overridden
// PORTS
//  clk            in   1  system clock; only clock in the block
//  reset          in   1  synchronous, active-high reset
//  button_raw     in   1  raw pin, asynchronous to clk, may bounce
//  btn_level      out  1  debounced level, 1 = pressed; drives PIO in_port
//  press_pulse    out  1  one-cycle strobe on each debounced 0->1 of btn_level
//  release_pulse  out  1  one-cycle strobe on each debounced 1->0 of btn_level
//  press_count    out  8  number of debounced presses since reset, wraps 255->0
// BEHAVIOUR
//  Reset (sampled on posedge clk while reset=1; overrides all else):
//   - sync flops load the released pin value (ACTIVE_LOW ? 1 : 0).
//   - btn_level=0, press_pulse=0, release_pulse=0, press_count=0.
//   - state=STABLE, cnt=0.
//  Synchroniser: plain shift chain; last stage normalised -> s (1 = pressed).
//   No other logic reads button_raw.
//  FSM, states STABLE / CONFIRM, all transitions on posedge clk:
//   STABLE:  s==btn_level -> stay, cnt=0.
//            s!=btn_level -> CONFIRM, cnt=1.
//   CONFIRM: s==btn_level -> STABLE, cnt=0; glitch rejected, no outputs change.
//            s!=btn_level and cnt<DEBOUNCE_CYCLES -> cnt=cnt+1.
//            s!=btn_level and cnt==DEBOUNCE_CYCLES -> all of:
//              btn_level<=s; matching pulse<=1; STABLE; cnt=0.
//  Latency: raw level settled before edge E0 -> btn_level changes at edge
//   E0+SYNC_STAGES+DEBOUNCE_CYCLES, provided the raw level holds throughout.
//  Strobes:
//   - press_pulse/release_pulse assert in the same cycle btn_level changes,
//     last exactly one cycle, and are never high together.
//   - btn_level cannot toggle on consecutive cycles, so pulses are >=2 cycles apart.
//  press_count: +1 on the edge that sets press_pulse; modulo 256, 255+1 -> 0;
//   release never modifies it.
//  Bounce: any return of s to btn_level during CONFIRM restarts the
//   qualification from zero; a partial count is never resumed.
//  Reset mid-CONFIRM: count discarded, no pulse.
//   Button held through reset release: treated as a new press; press_pulse
//   fires SYNC_STAGES+DEBOUNCE_CYCLES edges after reset deasserts.
//  Counter width: cnt is CNT_W bits and never exceeds DEBOUNCE_CYCLES, so no overflow.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1 unless noted)
//  1 Reset: raw=1, reset for 3 cycles -> all outputs 0 on the first edge; stay 0 for 20 cycles.
//  2 Clean press: raw 1->0 before edge E0 and held -> btn_level=1 and press_pulse=1
//    at E0+6, press_pulse=0 at E0+7, press_count=1.
//    Release with raw held 1 -> release_pulse at +6, count still 1.
//  3 Bounce: raw low 3 cycles, high 1, low 2, high 1, then low held -> no early
//    change; exactly one press_pulse, 6 edges after the final low edge; count +1.
//  4 Wrap: 256 clean press/release pairs -> press_count reads 0 after the last
//    press, 255 immediately before it.
//  5 Reset mid-operation: assert reset 2 edges into CONFIRM, raw held low ->
//    no pulse during reset; press_pulse 6 edges after reset deasserts; count=1.
//  6 ACTIVE_LOW=0, DEBOUNCE_CYCLES=1: raw 0->1 held -> press_pulse at E0+3;
//    a 1-cycle raw glitch produces no pulse.

Source files
------------

// File: rtl/nios_pushbutton_debounce_if.sv
// Pushbutton conditioning signal bundle: raw pin in, debounced level/strobes/count out.
interface nios_pushbutton_debounce_if;
  logic       button_raw;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  modport master (
    output button_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  press_count
  );

  modport slave (
    input  button_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output press_count
  );
endinterface

// File: rtl/nios_pushbutton_debounce.sv
// Synchronises, debounces and edge-detects one board pushbutton for the Nios PIO,
// with an 8-bit wrap-around press counter.
module nios_pushbutton_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  nios_pushbutton_debounce_if.slave pb
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {STABLE, CONFIRM} state_t;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_pressed;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [7:0]       count_q, count_d;

  // Stage 0: metastability shift chain, reset to the released pin level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pb.button_raw};
    end
  end

  assign sync_pressed = sync_p0[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Stage 1: stability qualification; any bounce back restarts from zero
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
    unique case (state_q)
      STABLE: begin
        if (sync_pressed != level_q) begin
          state_d = CONFIRM;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CONFIRM: begin
        if (sync_pressed == level_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          level_d   = sync_pressed;
          press_d   = sync_pressed;
          release_d = ~sync_pressed;
          state_d   = STABLE;
          cnt_d     = '0;
          if (sync_pressed) count_d = count_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  assign pb.btn_level     = level_q;
  assign pb.press_pulse   = press_q;
  assign pb.release_pulse = release_q;
  assign pb.press_count   = count_q;

endmodule

// File: tb/tb_nios_pushbutton_debounce.sv
// Bench for nios_pushbutton_debounce: directed scenarios plus randomized bouncing
// checked against a run-length reference model, on two parameterisations.
module tb_nios_pushbutton_debounce;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  nios_pushbutton_debounce_if bus_a ();
  nios_pushbutton_debounce_if bus_b ();

  nios_pushbutton_debounce #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .pb(bus_a.slave)
  );

  nios_pushbutton_debounce #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .pb(bus_b.slave)
  );

  // Reference: the level flips once the synchronised "pressed" value has
  // disagreed with it on DEBOUNCE_CYCLES+1 consecutive edges.
  int m_deb [2] = '{4, 1};
  bit m_hist [2][SYNC];
  bit m_level [2];
  bit m_press [2];
  bit m_rel [2];
  int m_run [2];
  int m_presses [2];

  always @(posedge clk) begin
    bit rp;
    bit s;
    for (int i = 0; i < 2; i++) begin
      rp = (i == 0) ? !bus_a.button_raw : bus_b.button_raw;
      if (reset) begin
        for (int j = 0; j < SYNC; j++) m_hist[i][j] = 1'b0;
        m_level[i] = 1'b0; m_press[i] = 1'b0; m_rel[i] = 1'b0;
        m_run[i] = 0; m_presses[i] = 0;
      end else begin
        s = m_hist[i][SYNC-1];
        for (int j = SYNC - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
        m_hist[i][0] = rp;
        m_press[i] = 1'b0; m_rel[i] = 1'b0;
        if (s != m_level[i]) m_run[i] = m_run[i] + 1;
        else m_run[i] = 0;
        if (m_run[i] == m_deb[i] + 1) begin
          m_level[i] = s;
          m_press[i] = s;
          m_rel[i]   = !s;
          if (s) m_presses[i] = m_presses[i] + 1;
          m_run[i] = 0;
        end
      end
    end
  end

  task automatic test_reset();
    bus_a.button_raw = 1'b1;
    bus_b.button_raw = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse, bus_a.press_count} !== 11'd0) begin
      errors++;
      $display("FAIL reset_first_edge got %b exp 0", {bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse, bus_a.press_count});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse, bus_a.press_count,
           bus_b.btn_level, bus_b.press_pulse, bus_b.release_pulse, bus_b.press_count} !== 22'd0) begin
        errors++;
        $display("FAIL reset_idle k=%0d a=%b b=%b exp all zero", k,
                 {bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse, bus_a.press_count},
                 {bus_b.btn_level, bus_b.press_pulse, bus_b.release_pulse, bus_b.press_count});
      end
    end
    exp_cnt = 0;
  endtask

  task automatic test_clean_press();
    bus_a.button_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse} !== {k >= 6, k == 6, 1'b0}) begin
        errors++;
        $display("FAIL clean_press k=%0d got %b exp %b", k,
                 {bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse}, {k >= 6, k == 6, 1'b0});
      end
    end
    exp_cnt++;
    checks++;
    if (bus_a.press_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL clean_press_count got %0d exp %0d", bus_a.press_count, exp_cnt);
    end
    bus_a.button_raw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse} !== {k < 6, 1'b0, k == 6}) begin
        errors++;
        $display("FAIL clean_release k=%0d got %b exp %b", k,
                 {bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse}, {k < 6, 1'b0, k == 6});
      end
    end
    checks++;
    if (bus_a.press_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL release_count got %0d exp %0d", bus_a.press_count, exp_cnt);
    end
  endtask

  task automatic test_bounce();
    logic pat [8];
    pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 22; k++) begin
      bus_a.button_raw = (k < 8) ? pat[k] : 1'b0;
      @(negedge clk);
      checks++;
      if ({bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse} !== {k >= 13, k == 13, 1'b0}) begin
        errors++;
        $display("FAIL bounce k=%0d got %b exp %b", k,
                 {bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse}, {k >= 13, k == 13, 1'b0});
      end
    end
    exp_cnt++;
    checks++;
    if (bus_a.press_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL bounce_count got %0d exp %0d", bus_a.press_count, exp_cnt);
    end
    bus_a.button_raw = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_polarity_short();
    bus_b.button_raw = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({bus_b.btn_level, bus_b.press_pulse, bus_b.release_pulse} !== {k >= 3, k == 3, 1'b0}) begin
        errors++;
        $display("FAIL polarity_press k=%0d got %b exp %b", k,
                 {bus_b.btn_level, bus_b.press_pulse, bus_b.release_pulse}, {k >= 3, k == 3, 1'b0});
      end
    end
    checks++;
    if (bus_b.press_count !== 8'd1) begin
      errors++;
      $display("FAIL polarity_count got %0d exp 1", bus_b.press_count);
    end
    bus_b.button_raw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({bus_b.btn_level, bus_b.release_pulse} !== {k < 3, k == 3}) begin
        errors++;
        $display("FAIL polarity_release k=%0d got %b exp %b", k,
                 {bus_b.btn_level, bus_b.release_pulse}, {k < 3, k == 3});
      end
    end
    bus_b.button_raw = 1'b1;
    @(negedge clk);
    bus_b.button_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({bus_b.btn_level, bus_b.press_pulse} !== 2'b00) begin
        errors++;
        $display("FAIL glitch k=%0d got %b exp 00", k, {bus_b.btn_level, bus_b.press_pulse});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bus_a.button_raw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (k < 4) begin
        if (bus_a.press_pulse !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_pre k=%0d got %b exp 0", k, bus_a.press_pulse);
        end
      end else if ({bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse, bus_a.press_count} !== 11'd0) begin
        errors++;
        $display("FAIL reset_mid_hold k=%0d got %b exp 0", k,
                 {bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse, bus_a.press_count});
      end
      if (k == 3) reset = 1'b1;
    end
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checks++;
      if ({bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse} !== {k >= 6, k == 6, 1'b0}) begin
        errors++;
        $display("FAIL reset_mid_press k=%0d got %b exp %b", k,
                 {bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse}, {k >= 6, k == 6, 1'b0});
      end
    end
    checks++;
    if (bus_a.press_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_mid_count got %0d exp 1", bus_a.press_count);
    end
    bus_a.button_raw = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        checks++;
        if (bus_a.press_count !== 8'd255) begin
          errors++;
          $display("FAIL wrap_before_last got %0d exp 255", bus_a.press_count);
        end
      end
      bus_a.button_raw = 1'b0;
      repeat (7) @(negedge clk);
      checks++;
      if (bus_a.press_count !== 8'((i + 1) % 256)) begin
        errors++;
        $display("FAIL wrap_count i=%0d got %0d exp %0d", i, bus_a.press_count, (i + 1) % 256);
      end
      bus_a.button_raw = 1'b1;
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic test_random();
    int hold_a = 0;
    int hold_b = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hold_a == 0) begin
        bus_a.button_raw = 1'($urandom_range(0, 1));
        hold_a = $urandom_range(1, 8);
      end
      if (hold_b == 0) begin
        bus_b.button_raw = 1'($urandom_range(0, 1));
        hold_b = $urandom_range(1, 4);
      end
      hold_a--;
      hold_b--;
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      checks++;
      if ({bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse, bus_a.press_count} !==
          {m_level[0], m_press[0], m_rel[0], 8'(m_presses[0])}) begin
        errors++;
        $display("FAIL random_a c=%0d got %b exp %b", c,
                 {bus_a.btn_level, bus_a.press_pulse, bus_a.release_pulse, bus_a.press_count},
                 {m_level[0], m_press[0], m_rel[0], 8'(m_presses[0])});
      end
      checks++;
      if ({bus_b.btn_level, bus_b.press_pulse, bus_b.release_pulse, bus_b.press_count} !==
          {m_level[1], m_press[1], m_rel[1], 8'(m_presses[1])}) begin
        errors++;
        $display("FAIL random_b c=%0d got %b exp %b", c,
                 {bus_b.btn_level, bus_b.press_pulse, bus_b.release_pulse, bus_b.press_count},
                 {m_level[1], m_press[1], m_rel[1], 8'(m_presses[1])});
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_polarity_short();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
